rv_instr_encoder: RTL and testbench
===================================

// Module: rv_instr_encoder
// PURPOSE
//  Packs RV32I-subset instruction descriptors (class, register indices, funct3, immediate) into
//  32-bit machine words and writes them sequentially into instruction memory. Inverse of the ID stage.
//  Used by the boot/program loader and by test harnesses to fill IMEM. Buffered through a FIFO.
// PARAMETERS
//  DEPTH      4       FIFO entries between encoder and IMEM write port (power of 2, >=2)
//  ADDR_W     32      IMEM byte-address width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       synchronous active-low reset
//  start        in   1       pulse in IDLE: load address counter, enter RUN
//  start_addr   in   ADDR_W  first write address (bits[1:0] forced to 0)
//  in_valid     in   1       descriptor valid
//  in_ready     out  1       descriptor accepted when in_valid&&in_ready
//  in_class     in   3       0=R 1=I(addi) 2=IL(load) 3=S 4=B 5=J, 6/7 illegal
//  in_rd        in   5       destination register (R/I/IL/J)
//  in_rs1       in   5       source 1 (R/I/IL/S/B)
//  in_rs2       in   5       source 2 (R/S/B)
//  in_funct3    in   3       funct3 field (ignored for J)
//  in_sub       in   1       R only: 1 -> funct7=7'b0100000, else 0
//  in_imm       in   32      signed byte-offset / immediate
//  in_last      in   1       marks final descriptor of a program
//  imem_we      out  1       write strobe (valid)
//  imem_ready   in   1       memory accepts write when imem_we&&imem_ready
//  imem_addr    out  ADDR_W  word-aligned write address
//  imem_wdata   out  32      encoded instruction
//  err          out  1       one-cycle pulse: accepted descriptor dropped
//  err_cnt      out  8       saturating count of dropped descriptors
//  busy         out  1       state != IDLE
//  done         out  1       one-cycle pulse when program fully written
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, addr=0, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//   err=0, err_cnt=0, busy=0, done=0. Reset mid-operation discards FIFO contents and pending last.
//  FSM: IDLE -start-> RUN; RUN -accept with in_last-> DRAIN; DRAIN -FIFO empty and no write
//   in flight-> IDLE with done=1 that cycle. start ignored outside IDLE.
//  in_ready = (state==RUN) && (fifo_count<DEPTH). A full FIFO blocks push even when popping that cycle.
//  Encoding is combinational from the descriptor and pushed into the FIFO on the accepting edge.
//   Opcodes: R 0110011, I 0010011, IL 0000011, S 0100011, B 1100011, J 1101111.
//   R  {sub?0100000:0, rs2, rs1, f3, rd, op}
//   I/IL {imm[11:0], rs1, f3, rd, op}
//   S  {imm[11:5], rs2, rs1, f3, imm[4:0], op}
//   B  {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
//   J  {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
//  Drop (no push, err=1 next cycle, err_cnt+1 saturating at 255), applied to:
//   - illegal class
//   - I/IL/S imm outside -2048..2047
//   - B imm outside -4096..4094 or imm[0]=1
//   - J imm outside +/-1MiB or imm[0]=1
//   A dropped descriptor carrying in_last still moves the FSM to DRAIN.
//  Latency: accepted on edge N -> imem_we=1 from cycle N+1 if the FIFO was empty.
//  IMEM port presents the FIFO head, registered. The head pops on imem_we&&imem_ready.
//   imem_addr increments by 4 after each completed write and wraps modulo 2^ADDR_W.
//   imem_addr/imem_wdata are held stable while imem_we&&!imem_ready.
//  Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo DEPTH.
// TESTING
//  1 start, start_addr=0x100; R rd3 rs1=1 rs2=2 f3=0 sub=0 -> imem 0x100 <= 0x002081B3
//  2 R rd5 rs1=6 rs2=7 sub=1 -> 0x407302B3 at 0x104; I rd1 rs1=0 imm=-1 -> 0xFFF00093 at 0x108
//  3 S rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423; B rs1=1 rs2=2 f3=0 imm=8 -> 0x00208463;
//    J rd1 imm=16, last=1 -> 0x010000EF, then done pulse and busy=0
//  4 imem_ready=0, push 5 descriptors -> in_ready low after 4th; imem_addr/wdata stable;
//    release -> 4 words written in order, then 5th
//  5 B imm=7; class=6; I imm=2048 -> 3 err pulses, err_cnt=3, no IMEM writes, addr unchanged
//  6 rst_n=0 with 3 FIFO entries pending -> next cycle all outputs at reset values; start restarts cleanly

Source files
------------

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs RV32I-subset instruction descriptors into 32-bit words
// and streams them through a small FIFO into sequential instruction-memory writes.
// Descriptors whose class is illegal or whose immediate cannot be represented
// are dropped and reported through err/err_cnt instead of being written.
module rv_instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_sub,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic              busy,
    output logic              done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_IL = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [31:0]       fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_count;

    logic [ADDR_W-1:0] addr;
    logic              err_q;
    logic [7:0]        err_cnt_q;

    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              imm12_ok;
    logic              immb_ok;
    logic              immj_ok;

    logic              accept;
    logic              push;
    logic              pop;

    // Handshake decode: a full FIFO refuses new descriptors even if the head pops this cycle.
    assign in_ready = (state == RUN) && (fifo_count < FULL_CNT);
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc_ok;
    assign pop      = imem_we && imem_ready;

    assign imm12_ok = ($signed(in_imm) >= -32'sd2048) && ($signed(in_imm) <= 32'sd2047);
    assign immb_ok  = ($signed(in_imm) >= -32'sd4096) && ($signed(in_imm) <= 32'sd4094) && !in_imm[0];
    assign immj_ok  = ($signed(in_imm) >= -32'sd1048576) && ($signed(in_imm) <= 32'sd1048574) && !in_imm[0];

    // Combinational encoder: builds the machine word and flags whether it is representable.
    always_comb begin
        enc_word = 32'h0;
        enc_ok   = 1'b0;
        case (in_class)
            3'd0: begin
                enc_word = {(in_sub ? 7'b0100000 : 7'b0000000), in_rs2, in_rs1, in_funct3, in_rd, OP_R};
                enc_ok   = 1'b1;
            end
            3'd1: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
                enc_ok   = imm12_ok;
            end
            3'd2: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IL};
                enc_ok   = imm12_ok;
            end
            3'd3: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
                enc_ok   = imm12_ok;
            end
            3'd4: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OP_B};
                enc_ok   = immb_ok;
            end
            3'd5: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_J};
                enc_ok   = immj_ok;
            end
            default: begin
                enc_word = 32'h0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // State register for the load sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a final descriptor (kept or dropped) ends RUN; DRAIN waits for an empty FIFO.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && in_last) state_next = DRAIN;
            DRAIN:   if (fifo_count == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FIFO bookkeeping: pointers wrap naturally, simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are only visible while the count says the slot is occupied.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= enc_word;
    end

    // Write address: loaded word-aligned on start, advanced after each accepted memory write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
        end else if ((state == IDLE) && start) begin
            addr <= start_addr & ~ADDR_W'(3);
        end else if (pop) begin
            addr <= addr + ADDR_W'(4);
        end
    end

    // Drop reporting: one-cycle pulse after the drop and a saturating tally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_q <= accept && !enc_ok;
            if (accept && !enc_ok && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign imem_we    = (fifo_count != '0);
    assign imem_addr  = addr;
    assign imem_wdata = imem_we ? fifo_mem[rd_ptr] : 32'h0;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state != IDLE);
    assign done       = (state == DRAIN) && (fifo_count == '0);

endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: drives directed and random descriptor programs into the
// encoder; a reference model computes each expected word and address into a
// scoreboard queue, and a monitor compares DUT outputs every cycle.
module tb_rv_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_sub;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              err;
    logic [7:0]        err_cnt;
    logic              busy;
    logic              done;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          drop_cycle = -1;
    int          exp_err_cnt = 0;
    bit          m_busy = 1'b0;
    bit          m_drain = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    int          writes_seen = 0;
    int          done_seen = 0;
    int          err_seen = 0;
    bit          rand_ready = 1'b0;
    bit          fixed_ready = 1'b1;

    rv_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_sub     (in_sub),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .err        (err),
        .err_cnt    (err_cnt),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time the expected err pulse.
    always @(posedge clk) cycle <= cycle + 1;

    // Memory-side backpressure: random during soak, otherwise a fixed level.
    always @(posedge clk) begin
        #1;
        imem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
    endfunction

    // Representability of the immediate for each instruction class.
    function automatic bit model_legal(input int cls, input int imm);
        case (cls)
            0:       return 1'b1;
            1, 2, 3: return (imm >= -2048) && (imm <= 2047);
            4:       return (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
            5:       return (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Instruction formats assembled from field values with shifts and ORs.
    function automatic logic [31:0] model_encode(input int cls, input int rd, input int rs1,
                                                 input int rs2, input int f3, input bit sub,
                                                 input int imm);
        logic [31:0] u;
        logic [31:0] base;
        u = imm;
        base = (32'(rs1) << 15) | (32'(f3) << 12);
        case (cls)
            0: return (sub ? 32'h4000_0000 : 32'h0) | (32'(rs2) << 20) | base | (32'(rd) << 7) | 32'h33;
            1: return (fld(u, 11, 0) << 20) | base | (32'(rd) << 7) | 32'h13;
            2: return (fld(u, 11, 0) << 20) | base | (32'(rd) << 7) | 32'h03;
            3: return (fld(u, 11, 5) << 25) | (32'(rs2) << 20) | base | (fld(u, 4, 0) << 7) | 32'h23;
            4: return (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25) | (32'(rs2) << 20) | base |
                      (fld(u, 4, 1) << 8) | (fld(u, 11, 11) << 7) | 32'h63;
            5: return (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21) | (fld(u, 11, 11) << 20) |
                      (fld(u, 19, 12) << 12) | (32'(rd) << 7) | 32'h6F;
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard monitor: every cycle compares the write port and status outputs to the model.
    always @(negedge clk) begin : monitor
        int n;
        if (rst_n) begin
            n = sb.size();
            checkOutput("imem_we", {31'b0, imem_we}, {31'b0, (n != 0)});
            if (n != 0) begin
                checkOutput("imem_addr", imem_addr, sb[0].addr);
                checkOutput("imem_wdata", imem_wdata, sb[0].data);
                if (imem_we && imem_ready) begin
                    void'(sb.pop_front());
                    writes_seen++;
                end
            end
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (m_busy && !m_drain && (n < DEPTH))});
            checkOutput("busy", {31'b0, busy}, {31'b0, m_busy});
            checkOutput("err", {31'b0, err}, {31'b0, (drop_cycle == cycle)});
            checkOutput("err_cnt", {24'b0, err_cnt}, 32'(exp_err_cnt));
            checkOutput("done", {31'b0, done}, {31'b0, (m_drain && (n == 0))});
            if (done) done_seen++;
            if (err) err_seen++;
            if (m_drain && (n == 0)) begin
                m_busy  = 1'b0;
                m_drain = 1'b0;
            end
        end
    end

    // Present one descriptor, wait for acceptance, then record its expected effect.
    task automatic applyStimulus(input int cls, input int rd, input int rs1, input int rs2,
                                 input int f3, input bit sub, input int imm, input bit last,
                                 input bit use_lit, input logic [31:0] lit);
        bit got;
        got       = 1'b0;
        in_valid  = 1'b1;
        in_class  = 3'(cls);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_sub    = sub;
        in_imm    = imm;
        in_last   = last;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=no_accept expected=accept class=%0d", cls);
            in_valid = 1'b0;
            in_last  = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (model_legal(cls, imm)) begin
                sb.push_back('{addr: exp_addr,
                               data: (use_lit ? lit : model_encode(cls, rd, rs1, rs2, f3, sub, imm))});
                exp_addr = exp_addr + 32'd4;
            end else begin
                drop_cycle = cycle;
                if (exp_err_cnt < 255) exp_err_cnt++;
            end
            if (last) m_drain = 1'b1;
        end
    endtask

    task automatic doStart(input logic [31:0] a);
        start      = 1'b1;
        start_addr = a;
        @(posedge clk);
        #1;
        start    = 1'b0;
        m_busy   = 1'b1;
        exp_addr = a & ~32'h3;
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!m_busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual=busy expected=idle");
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_imm();
        int bnd[14];
        bnd = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                -1048577, -1048576, 1048574, 1048575, 1048576};
        case ($urandom_range(0, 5))
            0:       return int'($urandom_range(0, 4000)) - 2000;
            1:       return bnd[$urandom_range(0, 13)];
            2:       return int'($urandom);
            3:       return int'($urandom_range(0, 2097152)) - 1048576;
            default: return (int'($urandom_range(0, 2000)) - 1000) * 2;
        endcase
    endfunction

    // Global time limit so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed programs, random soak, saturation, mid-run reset.
    initial begin
        int wb;
        int db;
        int eb;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        in_valid   = 1'b0;
        in_class   = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_funct3  = '0;
        in_sub     = 1'b0;
        in_imm     = '0;
        in_last    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("rst_imem_we", {31'b0, imem_we}, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] directed encodings");
        doStart(32'h0000_0102);
        applyStimulus(0, 3, 1, 2, 0, 0, 0, 0, 1, 32'h0020_81B3);
        @(negedge clk);
        checkOutput("latency_we", {31'b0, imem_we}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(0, 5, 6, 7, 0, 1, 0, 0, 1, 32'h4073_02B3);
        applyStimulus(1, 1, 0, 0, 0, 0, -1, 0, 1, 32'hFFF0_0093);
        applyStimulus(3, 0, 1, 2, 2, 0, 8, 0, 1, 32'h0020_A423);
        applyStimulus(4, 0, 1, 2, 0, 0, 8, 0, 1, 32'h0020_8463);
        db = done_seen;
        applyStimulus(5, 1, 0, 0, 0, 0, 16, 1, 1, 32'h0100_00EF);
        waitIdle();
        checkOutput("t3_done_pulses", 32'(done_seen - db), 32'd1);
        checkOutput("t3_busy", {31'b0, busy}, 32'd0);
        checkOutput("t3_addr", imem_addr, 32'h0000_0118);
        checkOutput("t3_writes", 32'(writes_seen), 32'd6);

        $display("[TB] backpressure");
        fixed_ready = 1'b0;
        doStart(32'h0000_0200);
        wb = writes_seen;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, i + 1, i + 2, i + 3, i, i[0], 0, 0, 0, 32'h0);
        end
        fork
            applyStimulus(0, 9, 10, 11, 7, 1, 0, 1, 0, 32'h0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("t4_full_in_ready", {31'b0, in_ready}, 32'd0);
                    checkOutput("t4_stall_addr", imem_addr, 32'h0000_0200);
                end
                fixed_ready = 1'b1;
            end
        join
        waitIdle();
        checkOutput("t4_writes", 32'(writes_seen - wb), 32'd5);
        checkOutput("t4_addr", imem_addr, 32'h0000_0214);

        $display("[TB] drops");
        doStart(32'h0000_0300);
        wb = writes_seen;
        eb = err_seen;
        applyStimulus(4, 0, 1, 2, 0, 0, 7, 0, 0, 32'h0);
        applyStimulus(6, 1, 1, 1, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 2048, 1, 0, 32'h0);
        waitIdle();
        checkOutput("t5_err_cnt", {24'b0, err_cnt}, 32'd3);
        checkOutput("t5_err_pulses", 32'(err_seen - eb), 32'd3);
        checkOutput("t5_writes", 32'(writes_seen - wb), 32'd0);
        checkOutput("t5_addr", imem_addr, 32'h0000_0300);

        $display("[TB] random programs");
        rand_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            logic [31:0] a;
            int n;
            int r;
            int cls;
            a = (p == 2) ? 32'hFFFF_FFF2 : $urandom;
            doStart(a);
            n = $urandom_range(8, 24);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                r   = $urandom_range(0, 15);
                cls = (r < 14) ? (r % 6) : (6 + r - 14);
                applyStimulus(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                              $urandom_range(0, 7), 1'($urandom_range(0, 1)), pick_imm(),
                              (i == n - 1), 0, 32'h0);
            end
            waitIdle();
            checkOutput("prog_end_addr", imem_addr, exp_addr);
        end
        rand_ready  = 1'b0;
        fixed_ready = 1'b1;

        $display("[TB] err_cnt saturation");
        doStart(32'h0000_0800);
        for (int i = 0; i < 258; i++) begin
            applyStimulus(7, 0, 0, 0, 0, 0, 0, (i == 257), 0, 32'h0);
        end
        waitIdle();
        checkOutput("err_cnt_sat", {24'b0, err_cnt}, 32'd255);

        $display("[TB] reset mid-operation");
        fixed_ready = 1'b0;
        @(posedge clk);
        #1;
        doStart(32'h0000_0400);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, i + 4, i, i + 1, 0, 0, 0, 0, 0, 32'h0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        m_busy      = 1'b0;
        m_drain     = 1'b0;
        exp_err_cnt = 0;
        drop_cycle  = -1;
        rst_n       = 1'b1;
        @(negedge clk);
        checkOutput("t6_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("t6_imem_we", {31'b0, imem_we}, 32'd0);
        checkOutput("t6_imem_addr", imem_addr, 32'h0);
        checkOutput("t6_imem_wdata", imem_wdata, 32'h0);
        checkOutput("t6_err", {31'b0, err}, 32'd0);
        checkOutput("t6_err_cnt", {24'b0, err_cnt}, 32'd0);
        checkOutput("t6_busy", {31'b0, busy}, 32'd0);
        checkOutput("t6_done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        fixed_ready = 1'b1;
        wb = writes_seen;
        doStart(32'h0000_0040);
        applyStimulus(1, 2, 3, 0, 0, 0, -2048, 0, 0, 32'h0);
        applyStimulus(5, 1, 0, 0, 0, 0, -1048576, 1, 0, 32'h0);
        waitIdle();
        checkOutput("t6_restart_writes", 32'(writes_seen - wb), 32'd2);
        checkOutput("t6_restart_addr", imem_addr, 32'h0000_0048);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
